decode_stage_pipe: RTL and testbench
====================================

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of register data, PC and immediates; DATA_W >= 16.
REQ-002 Parameter BYPASS, default 1, SHALL enable same-cycle write-through from the write port to the read ports.
REQ-003 Parameter HAZARD_EN, default 1, SHALL enable load-use and branch-dependency stall insertion.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 in_valid / in_ready  in/out  1/1  fetch-side handshake for in_inst and in_pc_next.
REQ-007 in_inst  in  16  instruction word, opcode in [15:12].
REQ-008 in_pc_next  in  DATA_W  address of the next sequential instruction.
REQ-009 flags  in  3  architectural {Z,V,N}.
REQ-010 wb_we, wb_rd, wb_data  in  1/4/DATA_W  register-file write port.
REQ-011 out_valid / out_ready  out/in  1/1  execute-side handshake.
REQ-012 out_rs1_data, out_rs2_data, out_imm  out  DATA_W each  registered operands and immediate.
REQ-013 out_rd, out_aluop  out  4/4  registered destination ID and ALU operation.
REQ-014 out_ctrl  out  8  registered {ALUSrc,Z_en,NV_en,MemEnable,MemWrite,RegWrite,MemToReg,PCS}.
REQ-015 br_taken  out  1  one-cycle pulse: the accepted branch is taken; fetch SHALL flush.
REQ-016 br_target  out  DATA_W  taken-branch target, valid with br_taken.
REQ-017 halted  out  1  sticky halt indication.

Function
REQ-018 The register file SHALL hold 16 x DATA_W entries, with R0 reading as 0 and writes to R0 ignored.
REQ-019 When BYPASS=1, a read whose ID matches wb_rd while wb_we=1 SHALL return wb_data in the same cycle.
REQ-020 Source selection: LLB/LHB SHALL read Rd as src1; SW SHALL read Rd as src2; all others SHALL read [7:4] and [3:0].
REQ-021 Immediates: LW/SW SHALL sign-extend [3:0]; shifts/rotates SHALL zero-extend [3:0]; LLB/LHB SHALL zero-extend [7:0]; all to DATA_W.
REQ-022 An instruction SHALL be accepted when in_valid & in_ready.
REQ-023 in_ready SHALL equal (~out_valid | out_ready) & ~stall & ~halted.
REQ-024 An accepted instruction SHALL appear on out_* with out_valid=1 in the next cycle (latency 1).
REQ-025 out_* SHALL hold stable while out_valid & ~out_ready.
REQ-026 When the output advances without an acceptance, out_valid SHALL go to 0 (bubble).
REQ-027 stall (HAZARD_EN=1) SHALL be asserted when out_valid and the output holds LW with out_rd != 0 matching a source register the incoming instruction uses.
REQ-028 stall (HAZARD_EN=1) SHALL also be asserted when the incoming instruction is BR and the output holds RegWrite with out_rd equal to its Rs.
REQ-029 stall (HAZARD_EN=1) SHALL also be asserted when the incoming instruction is B or BR and the output holds Z_en or NV_en.
REQ-030 B and BR SHALL be resolved at acceptance against flags and condition [11:9].
REQ-031 B target SHALL be in_pc_next + (sign-extended [8:0] << 1); BR target SHALL be Rs data.
REQ-032 On a taken branch, br_taken SHALL pulse exactly in the cycle after acceptance.
REQ-033 B and BR SHALL enter the output stage with RegWrite=0, MemWrite=0 and no flag enables.
REQ-034 Accepting HLT SHALL set halted the next cycle and forward HLT as a no-op; halted SHALL hold until reset.
REQ-035 A wb write and a read of the same register in one cycle SHALL obey REQ-019; with BYPASS=0 the read SHALL return the old value.

Reset
REQ-036 While rst_n=0 at a clock edge, all registers, out_valid, br_taken and halted SHALL be cleared, and out_* data SHALL be 0.
REQ-037 During reset in_ready SHALL be 0, and a reset mid-stall or mid-backpressure SHALL discard the held instruction.

Verification
REQ-038 Write R3=0x1234 via the wb port, then ADD R1,R3,R0 -> out_rs1_data=0x1234 after one cycle.
REQ-039 BYPASS=1 with wb R5=0xBEEF concurrent with decode of XOR R2,R5,R5 -> out_rs1_data = out_rs2_data = 0xBEEF.
REQ-040 LW R4 followed by ADD R6,R4,R1 -> in_ready=0 for 1 cycle, one bubble, then ADD issued.
REQ-041 B with cond EQ, Z=1, in_pc_next=0x0010, offset 0x004 -> br_taken pulse with br_target=0x0018.
REQ-042 out_ready held low for 3 cycles -> out_* stable, in_ready=0, no instruction lost.
REQ-043 HLT accepted -> halted=1 next cycle, in_ready stays 0; rst_n=0 clears halted.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Decode stage: 16-entry register file with optional write-through, operand and
// immediate decode, hazard stalls, branch resolution and one output register.
module decode_stage_pipe #(
  parameter int DATA_W    = 16,
  parameter int BYPASS    = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_inst,
  input  logic [DATA_W-1:0] in_pc_next,
  input  logic [2:0]        flags,
  input  logic              wb_we,
  input  logic [3:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [3:0]        out_rd,
  output logic [3:0]        out_aluop,
  output logic [7:0]        out_ctrl,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              halted
);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF;

  localparam int C_ALUSRC = 7, C_ZEN = 6, C_NVEN = 5, C_MEMEN = 4;
  localparam int C_MEMWR  = 3, C_REGWR = 2, C_MEM2REG = 1, C_PCS = 0;

  function automatic logic [7:0] decode_ctrl(input logic [3:0] op);
    logic [7:0] c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB: begin c[C_ZEN] = 1'b1; c[C_NVEN] = 1'b1; c[C_REGWR] = 1'b1; end
      OP_XOR:         begin c[C_ZEN] = 1'b1; c[C_REGWR] = 1'b1; end
      OP_RED, OP_PADDSB: c[C_REGWR] = 1'b1;
      OP_SLL, OP_SRA, OP_ROR: begin c[C_ALUSRC] = 1'b1; c[C_ZEN] = 1'b1; c[C_REGWR] = 1'b1; end
      OP_LW: begin
        c[C_ALUSRC] = 1'b1; c[C_MEMEN] = 1'b1; c[C_REGWR] = 1'b1; c[C_MEM2REG] = 1'b1;
      end
      OP_SW:          begin c[C_ALUSRC] = 1'b1; c[C_MEMEN] = 1'b1; c[C_MEMWR] = 1'b1; end
      OP_LLB, OP_LHB: begin c[C_ALUSRC] = 1'b1; c[C_REGWR] = 1'b1; end
      OP_PCS:         begin c[C_REGWR] = 1'b1; c[C_PCS] = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] imm_ext(input logic [15:0] inst);
    case (inst[15:12])
      OP_LW, OP_SW:           return {{(DATA_W-4){inst[3]}}, inst[3:0]};
      OP_SLL, OP_SRA, OP_ROR: return {{(DATA_W-4){1'b0}}, inst[3:0]};
      OP_LLB, OP_LHB:         return {{(DATA_W-8){1'b0}}, inst[7:0]};
      default:                return '0;
    endcase
  endfunction

  // flags are {Z,V,N}
  function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
    case (cond)
      3'd0:    return ~f[2];
      3'd1:    return f[2];
      3'd2:    return ~f[2] & ~f[0];
      3'd3:    return f[0];
      3'd4:    return f[2] | (~f[2] & ~f[0]);
      3'd5:    return f[0] | f[2];
      3'd6:    return f[1];
      default: return 1'b1;
    endcase
  endfunction

  logic [DATA_W-1:0] rf [16];
  logic [3:0]        opc, src1_id, src2_id;
  logic              use1, use2, is_b, is_br, is_branch;
  logic [DATA_W-1:0] rs1_data, rs2_data, b_target;
  logic signed [DATA_W-1:0] b_off;
  logic              stall, advance, accept;

  logic              vld_p1, br_taken_p1, halted_p1;
  logic [DATA_W-1:0] rs1_data_p1, rs2_data_p1, imm_p1, br_target_p1;
  logic [3:0]        rd_p1, aluop_p1;
  logic [7:0]        ctrl_p1;

  assign opc       = in_inst[15:12];
  assign src1_id   = (opc == OP_LLB || opc == OP_LHB) ? in_inst[11:8] : in_inst[7:4];
  assign src2_id   = (opc == OP_SW) ? in_inst[11:8] : in_inst[3:0];
  assign use1      = !(opc inside {OP_B, OP_PCS, OP_HLT});
  assign use2      = opc inside {OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB, OP_SW};
  assign is_b      = (opc == OP_B);
  assign is_br     = (opc == OP_BR);
  assign is_branch = is_b | is_br;
  assign b_off     = {{(DATA_W-10){in_inst[8]}}, in_inst[8:0], 1'b0};
  assign b_target  = in_pc_next + $unsigned(b_off);

  always_comb begin
    rs1_data = rf[src1_id];
    rs2_data = rf[src2_id];
    if (BYPASS != 0 && wb_we && wb_rd == src1_id) rs1_data = wb_data;
    if (BYPASS != 0 && wb_we && wb_rd == src2_id) rs2_data = wb_data;
    if (src1_id == 4'd0) rs1_data = '0;
    if (src2_id == 4'd0) rs2_data = '0;
  end

  always_comb begin
    stall = 1'b0;
    if (HAZARD_EN != 0 && vld_p1) begin
      if (aluop_p1 == OP_LW && rd_p1 != 4'd0 &&
          ((use1 && src1_id == rd_p1) || (use2 && src2_id == rd_p1)))
        stall = 1'b1;
      if (is_br && ctrl_p1[C_REGWR] && rd_p1 == in_inst[7:4]) stall = 1'b1;
      if (is_branch && (ctrl_p1[C_ZEN] | ctrl_p1[C_NVEN])) stall = 1'b1;
    end
  end

  assign advance  = ~vld_p1 | out_ready;
  assign in_ready = rst_n & advance & ~stall & ~halted_p1;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != 4'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // decode -> p1: output register, branch pulse and halt state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      rd_p1        <= '0;
      aluop_p1     <= '0;
      ctrl_p1      <= '0;
      br_taken_p1  <= 1'b0;
      br_target_p1 <= '0;
      halted_p1    <= 1'b0;
    end else begin
      br_taken_p1 <= accept & is_branch & cond_met(in_inst[11:9], flags);
      if (accept && is_branch) br_target_p1 <= is_br ? rs1_data : b_target;
      if (accept && opc == OP_HLT) halted_p1 <= 1'b1;
      if (accept) begin
        vld_p1      <= 1'b1;
        rs1_data_p1 <= rs1_data;
        rs2_data_p1 <= rs2_data;
        imm_p1      <= imm_ext(in_inst);
        rd_p1       <= in_inst[11:8];
        aluop_p1    <= opc;
        ctrl_p1     <= decode_ctrl(opc);
      end else if (advance) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign out_rs1_data = rs1_data_p1;
  assign out_rs2_data = rs2_data_p1;
  assign out_imm      = imm_p1;
  assign out_rd       = rd_p1;
  assign out_aluop    = aluop_p1;
  assign out_ctrl     = ctrl_p1;
  assign br_taken     = br_taken_p1;
  assign br_target    = br_target_p1;
  assign halted       = halted_p1;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed instruction sequences checked each cycle
// against a behavioural model, plus hand-computed literal expectations.
module tb_decode_stage_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_inst = 16'h0000;
  logic [15:0] in_pc_next = 16'h0000;
  logic [2:0]  flags = 3'b000;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_rd = 4'h0;
  logic [15:0] wb_data = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_rs1_data, out_rs2_data, out_imm;
  logic [3:0]  out_rd, out_aluop;
  logic [7:0]  out_ctrl;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halted;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  decode_stage_pipe #(.DATA_W(16), .BYPASS(1), .HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc_next(in_pc_next), .flags(flags),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rd(out_rd), .out_aluop(out_aluop), .out_ctrl(out_ctrl),
    .br_taken(br_taken), .br_target(br_target), .halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Control word per opcode: {ALUSrc,Z_en,NV_en,MemEnable,MemWrite,RegWrite,MemToReg,PCS}
  localparam logic [7:0] CTRL_TAB [16] = '{
    8'h64, 8'h64, 8'h44, 8'h04, 8'hC4, 8'hC4, 8'hC4, 8'h04,
    8'h96, 8'h98, 8'h84, 8'h84, 8'h00, 8'h00, 8'h05, 8'h00};

  logic [15:0] m_regs [16];
  logic        m_vld = 1'b0, m_halted = 1'b0, m_br = 1'b0;
  logic [15:0] m_rs1 = '0, m_rs2 = '0, m_imm = '0, m_tgt = '0;
  logic [3:0]  m_rd = '0, m_op = '0, m_opc;
  logic [7:0]  m_ctrl = '0;
  logic        m_acc;
  logic [15:0] m_n1, m_n2;
  bit          started = 1'b0;

  function automatic logic [3:0] m_src1(input logic [15:0] i);
    return (i[15:12] == 4'hA || i[15:12] == 4'hB) ? i[11:8] : i[7:4];
  endfunction
  function automatic logic [3:0] m_src2(input logic [15:0] i);
    return (i[15:12] == 4'h9) ? i[11:8] : i[3:0];
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] id);
    if (id == 4'd0) return 16'h0000;
    if (wb_we && wb_rd == id) return wb_data;
    return m_regs[id];
  endfunction

  function automatic logic [15:0] m_imm_of(input logic [15:0] i);
    case (i[15:12])
      4'h8, 4'h9:       return 16'(int'($signed(i[3:0])));
      4'h4, 4'h5, 4'h6: return {12'h000, i[3:0]};
      4'hA, 4'hB:       return {8'h00, i[7:0]};
      default:          return 16'h0000;
    endcase
  endfunction

  function automatic bit m_taken(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_stall();
    logic [3:0] op;
    bit u1, u2;
    op = in_inst[15:12];
    u1 = !(op inside {4'hC, 4'hE, 4'hF});
    u2 = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h9};
    if (!m_vld) return 1'b0;
    if (m_op == 4'h8 && m_rd != 4'd0 &&
        ((u1 && m_src1(in_inst) == m_rd) || (u2 && m_src2(in_inst) == m_rd))) return 1'b1;
    if (op == 4'hD && m_ctrl[2] && m_rd == in_inst[7:4]) return 1'b1;
    if ((op == 4'hC || op == 4'hD) && (m_ctrl[6] || m_ctrl[5])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return rst_n && (!m_vld || out_ready) && !m_stall() && !m_halted;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0000;
      m_vld = 0; m_halted = 0; m_br = 0;
      m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_tgt = '0; m_rd = '0; m_op = '0; m_ctrl = '0;
    end else begin
      m_acc = in_valid && m_ready();
      m_opc = in_inst[15:12];
      m_br  = 1'b0;
      if (m_acc) begin
        m_n1 = m_read(m_src1(in_inst));
        m_n2 = m_read(m_src2(in_inst));
        if (m_opc == 4'hC || m_opc == 4'hD) begin
          m_br = m_taken(in_inst[11:9], flags);
          if (m_br)
            m_tgt = (m_opc == 4'hC) ?
                    16'(int'(in_pc_next) + 2 * int'($signed(in_inst[8:0]))) : m_n1;
        end
        if (m_opc == 4'hF) m_halted = 1'b1;
        m_vld = 1'b1; m_rs1 = m_n1; m_rs2 = m_n2; m_imm = m_imm_of(in_inst);
        m_rd = in_inst[11:8]; m_op = m_opc; m_ctrl = CTRL_TAB[m_opc];
      end else if (out_ready) begin
        m_vld = 1'b0;
      end
      if (wb_we && wb_rd != 4'd0) m_regs[wb_rd] = wb_data;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, m_vld);
      chk("halted", halted, m_halted);
      chk("br_taken", br_taken, m_br);
      if (m_br) chk("br_target", br_target, m_tgt);
      if (m_vld) begin
        chk("out_rs1_data", out_rs1_data, m_rs1);
        chk("out_rs2_data", out_rs2_data, m_rs2);
        chk("out_imm", out_imm, m_imm);
        chk("out_rd", out_rd, m_rd);
        chk("out_aluop", out_aluop, m_op);
        chk("out_ctrl", out_ctrl, m_ctrl);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] inst, input logic [15:0] pc);
    int n;
    n = 0;
    in_inst = inst; in_pc_next = pc; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("send_accept", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_rs1_data", out_rs1_data, 16'h0000);
    chk("rst_ctrl", out_ctrl, 8'h00);
    rst_n = 1'b1;

    wb_we = 1'b1; wb_rd = 4'd3; wb_data = 16'h1234;
    tick();
    wb_we = 1'b0;
    send(16'h0130, 16'h0002);
    chk("add_rs1", out_rs1_data, 16'h1234);
    chk("add_ctrl", out_ctrl, 8'h64);

    wb_we = 1'b1; wb_rd = 4'd5; wb_data = 16'hBEEF;
    send(16'h2255, 16'h0004);
    wb_we = 1'b0;
    chk("xor_bypass_rs1", out_rs1_data, 16'hBEEF);
    chk("xor_bypass_rs2", out_rs2_data, 16'hBEEF);

    send(16'h841E, 16'h0006);
    chk("lw_imm_sext", out_imm, 16'hFFFE);
    in_inst = 16'h0641; in_valid = 1'b1;
    @(negedge clk);
    chk("load_use_stall", in_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("load_use_bubble", out_valid, 1'b0);
    chk("load_use_release", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("add_after_lw_rd", out_rd, 4'd6);

    flags = 3'b100;
    send(16'hC204, 16'h0010);
    chk("b_eq_taken", br_taken, 1'b1);
    chk("b_eq_target", br_target, 16'h0018);
    chk("b_ctrl_none", out_ctrl, 8'h00);
    tick();
    chk("b_pulse_end", br_taken, 1'b0);
    send(16'hC004, 16'h0020);
    chk("b_ne_not_taken", br_taken, 1'b0);
    send(16'hDE30, 16'h0030);
    chk("br_target_r3", br_target, 16'h1234);

    wb_we = 1'b1; wb_rd = 4'd9; wb_data = 16'h0ABC;
    tick();
    wb_we = 1'b0;
    send(16'hA940, 16'h0040);
    chk("llb_imm", out_imm, 16'h0040);
    chk("llb_reads_rd", out_rs1_data, 16'h0ABC);
    in_inst = 16'hDE90; in_valid = 1'b1;
    @(negedge clk);
    chk("br_dep_stall", in_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("br_dep_release", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("br_dep_target", br_target, 16'h0ABC);

    flags = 3'b000;
    send(16'hC5F0, 16'h0100);
    chk("b_gt_taken", br_taken, 1'b1);
    chk("b_gt_target", br_target, 16'h00E0);
    for (int f = 0; f < 8; f += 3) begin
      flags = 3'(f);
      for (int c = 0; c < 8; c++) send({4'hC, 3'(c), 9'h1F0}, 16'h0100);
    end

    send(16'h423F, 16'h0050);
    chk("sll_imm_zext", out_imm, 16'h000F);
    send(16'h9531, 16'h0052);
    chk("sw_rs2_is_rd", out_rs2_data, 16'hBEEF);
    chk("sw_ctrl", out_ctrl, 8'h98);
    send(16'hE700, 16'h0054);
    send(16'h3135, 16'h0056);
    send(16'h7125, 16'h0058);

    tick();
    out_ready = 1'b0;
    send(16'h0750, 16'h0060);
    in_inst = 16'h1835; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_rs1", out_rs1_data, 16'hBEEF);
      chk("bp_hold_rd", out_rd, 4'd7);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_rd", out_rd, 4'd8);
    chk("bp_next_op", out_aluop, 4'h1);

    tick();
    out_ready = 1'b0;
    send(16'h0750, 16'h0062);
    in_inst = 16'h1835; in_valid = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_bp_valid", out_valid, 1'b0);
    chk("rst_bp_data", out_rs1_data, 16'h0000);
    chk("rst_bp_ready", in_ready, 1'b0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    send(16'h0130, 16'h0002);
    chk("rf_cleared", out_rs1_data, 16'h0000);

    send(16'hF000, 16'h0070);
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_noop_ctrl", out_ctrl, 8'h00);
    in_inst = 16'h0130; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("halt_in_ready", in_ready, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("halt_cleared", halted, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
